// File: rtl/spm_pkg.sv
// Shared types and defaults for the SpMV row accumulator.
package spm_pkg;

  localparam int unsigned SPM_ELE_W_DEFAULT = 32;

  typedef enum logic {
    IDLE,
    ACCUM
  } lane_state_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } drain_state_t;

endpackage

// File: rtl/spm_row_acc_lane.sv
// One accumulator lane: open-row FSM, running sum and registered emission.
// Optional sticky carry-out flag when SPM_ACC_OVF_EN is defined.
module spm_row_acc_lane
  import spm_pkg::*;
#(
  parameter int unsigned W = SPM_ELE_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  input  logic [W-1:0] prod_i,
  input  logic [W-1:0] row_id_i,
  input  logic         drain_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_row_id_o,
  output logic [W-1:0] out_sum_o,
  output logic         idle_o,
  output logic         ovf_o
);

  lane_state_t  state_q, state_d;
  logic [W-1:0] cur_row_q, cur_row_d;
  logic [W-1:0] sum_q, sum_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_row_q, out_row_d;
  logic [W-1:0] out_sum_q, out_sum_d;
  logic [W-1:0] add_res;
  logic         acc_same;

  assign acc_same = (state_q == ACCUM) && in_valid_i && (row_id_i == cur_row_q);

`ifdef SPM_ACC_OVF_EN
  logic carry;
  logic ovf_q;

  assign {carry, add_res} = {1'b0, sum_q} + {1'b0, prod_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_q | (acc_same & carry);
  end

  assign ovf_o = ovf_q;
`else
  assign add_res = sum_q + prod_i;
  assign ovf_o   = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    cur_row_d   = cur_row_q;
    sum_d       = sum_q;
    out_valid_d = 1'b0;
    out_row_d   = out_row_q;
    out_sum_d   = out_sum_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          sum_d     = prod_i;
          cur_row_d = row_id_i;
          state_d   = ACCUM;
        end
      end
      ACCUM: begin
        if (acc_same) begin
          sum_d = add_res;
        end else if (in_valid_i) begin
          out_valid_d = 1'b1;
          out_row_d   = cur_row_q;
          out_sum_d   = sum_q;
          sum_d       = prod_i;
          cur_row_d   = row_id_i;
        end else if (drain_i) begin
          out_valid_d = 1'b1;
          out_row_d   = cur_row_q;
          out_sum_d   = sum_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments; reset clears everything, open rows included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_row_q   <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_sum_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_row_q   <= cur_row_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_sum_q   <= out_sum_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_row_id_o = out_row_q;
  assign out_sum_o    = out_sum_q;
  assign idle_o       = (state_q == IDLE);

endmodule

// File: rtl/spm_row_accumulator.sv
// Per-channel row accumulator array plus the global flush/drain sequencer.
// Define SPM_ACC_OVF_EN to enable sticky per-lane overflow flags.
module spm_row_accumulator
  import spm_pkg::*;
#(
  parameter int unsigned SPM_ELE_W = SPM_ELE_W_DEFAULT,
  parameter int unsigned CHAN_NUM  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SPM_ELE_W-1:0] prod_in    [CHAN_NUM],
  input  logic [SPM_ELE_W-1:0] row_id_in  [CHAN_NUM],
  input  logic [CHAN_NUM-1:0]  in_valid,
  input  logic                 flush,
  output logic [CHAN_NUM-1:0]  out_valid,
  output logic [SPM_ELE_W-1:0] out_row_id [CHAN_NUM],
  output logic [SPM_ELE_W-1:0] out_sum    [CHAN_NUM],
  output logic                 flush_done,
  output logic [CHAN_NUM-1:0]  ovf_flag
);

  drain_state_t        dstate_q, dstate_d;
  logic [CHAN_NUM-1:0] lane_idle;
  logic                drain;

  assign drain = (dstate_q == DRAIN);

  for (genvar g = 0; g < CHAN_NUM; g++) begin : g_lane
    spm_row_acc_lane #(
      .W(SPM_ELE_W)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid[g]),
      .prod_i      (prod_in[g]),
      .row_id_i    (row_id_in[g]),
      .drain_i     (drain),
      .out_valid_o (out_valid[g]),
      .out_row_id_o(out_row_id[g]),
      .out_sum_o   (out_sum[g]),
      .idle_o      (lane_idle[g]),
      .ovf_o       (ovf_flag[g])
    );
  end

  // Lanes still receiving beats keep the drain open until their input goes quiet.
  always_comb begin
    dstate_d = dstate_q;
    unique case (dstate_q)
      RUN:     if (flush) dstate_d = DRAIN;
      DRAIN:   if ((&lane_idle) && (in_valid == '0)) dstate_d = DONE;
      DONE:    dstate_d = RUN;
      default: dstate_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dstate_q <= RUN;
    else     dstate_q <= dstate_d;
  end

  assign flush_done = (dstate_q == DONE);

endmodule

// File: tb/tb_spm_row_accumulator.sv
// Directed bench for spm_row_accumulator with a queue scoreboard and negedge monitor.
module tb_spm_row_accumulator;

  localparam int W = 32;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] prod_in    [N];
  logic [W-1:0] row_id_in  [N];
  logic [N-1:0] in_valid;
  logic         flush;
  logic [N-1:0] out_valid;
  logic [W-1:0] out_row_id [N];
  logic [W-1:0] out_sum    [N];
  logic         flush_done;
  logic [N-1:0] ovf_flag;

  typedef struct {
    int           lane;
    logic [W-1:0] row;
    logic [W-1:0] sum;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  spm_row_accumulator #(
    .SPM_ELE_W(W),
    .CHAN_NUM (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .prod_in   (prod_in),
    .row_id_in (row_id_in),
    .in_valid  (in_valid),
    .flush     (flush),
    .out_valid (out_valid),
    .out_row_id(out_row_id),
    .out_sum   (out_sum),
    .flush_done(flush_done),
    .ovf_flag  (ovf_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic beat(input int lane, input logic [W-1:0] row, input logic [W-1:0] prod);
    in_valid[lane]  = 1'b1;
    row_id_in[lane] = row;
    prod_in[lane]   = prod;
  endtask

  task automatic push(input int lane, input logic [W-1:0] row, input logic [W-1:0] sum,
                      input int c);
    exp_t e;
    e.lane = lane;
    e.row  = row;
    e.sum  = sum;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    in_valid = '0;
    flush    = 1'b0;
  endtask

  // Monitor: pops an expectation for every emission and flush_done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (out_valid[i]) begin
          if (exp_q.size() == 0) begin
            check($sformatf("lane%0d spurious out_valid", i), out_valid[i], 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("emit lane", i, e.lane);
            check($sformatf("lane%0d row", i), out_row_id[i], e.row);
            check($sformatf("lane%0d sum", i), out_sum[i], e.sum);
            check($sformatf("lane%0d emit cycle", i), cyc, e.cyc);
          end
        end
      end
      if (flush_done) begin
        if (done_q.size() == 0) begin
          check("spurious flush_done", flush_done, 0);
        end else begin
          int c;
          c = done_q.pop_front();
          check("flush_done cycle", cyc, c);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_valid = '0;
    flush    = 1'b0;
    for (int i = 0; i < N; i++) begin
      prod_in[i]   = '0;
      row_id_in[i] = '0;
    end
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset flush_done", flush_done, 0);
    check("reset ovf_flag", ovf_flag, 0);
    check("reset out_sum[0]", out_sum[0], 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Single row on lane 0, closed by a new row ID, then drained.
    beat(0, 5, 3);  tick();
    beat(0, 5, 4);  tick();
    beat(0, 5, 10); tick();
    beat(0, 6, 1);  push(0, 5, 17, cyc + 1); tick();
    tick();
    check("hold out_valid[0]", out_valid[0], 0);
    check("hold out_row_id[0]", out_row_id[0], 5);
    check("hold out_sum[0]", out_sum[0], 17);
    flush = 1'b1; push(0, 6, 1, cyc + 2); done_q.push_back(cyc + 3); tick();
    repeat (4) tick();

    // Bubbles on lane 2 keep the row open.
    beat(2, 7, 2); tick();
    tick();
    tick();
    beat(2, 7, 5); tick();
    flush = 1'b1; push(2, 7, 7, cyc + 2); done_q.push_back(cyc + 3); tick();
    repeat (4) tick();

    // Wraparound on lane 1.
    beat(1, 3, 32'hFFFF_FFFF); tick();
    beat(1, 3, 2);             tick();
    flush = 1'b1; push(1, 3, 1, cyc + 2); done_q.push_back(cyc + 3); tick();
    repeat (4) tick();
`ifdef SPM_ACC_OVF_EN
    check("ovf_flag[1]", ovf_flag[1], 1);
`else
    check("ovf_flag[1]", ovf_flag[1], 0);
`endif
    check("ovf_flag[0]", ovf_flag[0], 0);

    // Flush coinciding with a new-row beat.
    beat(0, 4, 6); tick();
    beat(0, 9, 1); flush = 1'b1;
    push(0, 4, 6, cyc + 1); push(0, 9, 1, cyc + 2); done_q.push_back(cyc + 3);
    tick();
    repeat (4) tick();

    // Flush with every lane idle.
    flush = 1'b1; done_q.push_back(cyc + 2); tick();
    repeat (4) tick();

    // Two lanes change row together; extra flush during DRAIN and DONE is ignored.
    beat(5, 20, 11); beat(6, 30, 22); tick();
    beat(5, 21, 1);  beat(6, 31, 2);
    push(5, 20, 11, cyc + 1); push(6, 30, 22, cyc + 1); tick();
    flush = 1'b1;
    push(5, 21, 1, cyc + 2); push(6, 31, 2, cyc + 2); done_q.push_back(cyc + 3);
    tick();
    flush = 1'b1; tick();
    tick();
    flush = 1'b1; tick();
    repeat (4) tick();

    // Reset with an open row and an emission in flight.
    beat(3, 10, 2); tick();
    beat(3, 11, 4); tick();
    rst = 1'b1;
    #1;
    check("rst out_valid", out_valid, 0);
    check("rst out_row_id[3]", out_row_id[3], 0);
    check("rst out_sum[3]", out_sum[3], 0);
    check("rst ovf_flag", ovf_flag, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) tick();
    beat(3, 1, 8); tick();
    beat(3, 2, 1); push(3, 1, 8, cyc + 1); tick();
    flush = 1'b1; push(3, 2, 1, cyc + 2); done_q.push_back(cyc + 3); tick();
    repeat (5) tick();

    check("missing emissions", exp_q.size(), 0);
    check("missing flush_done", done_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
